fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I core, directly upstream of decode.
- Consumes Stall and Flush from the hazard unit and redirects to PCTargetE on a taken branch or jump.
- Talks to instruction memory over a req/valid handshake with variable latency, and inserts bubbles while memory is waiting.
- Exposes saturating perf counters.

Parameters:
- RESET_PC, 32'hBFC00000, PC loaded on reset.
- CNT_WIDTH, 32, perf counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- Stall  in  1  hold IF/ID and PC (load-use hazard)
- Flush  in  1  control hazard; redirect to PCTargetE
- PCTargetE  in  32  branch/jump target from execute
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; stable while imem_req=1 until imem_valid
- imem_valid  in  1  response valid (may arrive in the same cycle as req)
- imem_rdata  in  32  instruction word
- InstrD  out  32  instruction to decode
- PCD  out  32  PC of InstrD
- PCPlus4D  out  32  PCD+4
- ValidD  out  1  InstrD is real (0 = bubble)
- ImemWait  out  1  fetch waiting on memory this cycle
- stall_cnt  out  CNT_WIDTH  cycles with Stall=1
- flush_cnt  out  CNT_WIDTH  cycles with Flush=1
- bubble_cnt  out  CNT_WIDTH  bubbles inserted due to memory wait

Behaviour:
- Reset values: PCF=RESET_PC, state=FETCH, InstrD=NOP (32'h00000013), PCD=0, PCPlus4D=0, ValidD=0, all counters=0, hold buffer=0.
- Priority everywhere: rst > Flush > Stall > normal.
- imem_req=1 in FETCH and DROP, 0 in HOLD. imem_addr=PCF in FETCH/HOLD and the old PCF in DROP. ImemWait=1 when (FETCH and !imem_valid) or DROP.
- State FETCH:
  - imem_valid, no Stall, no Flush: IF/ID <= {imem_rdata, PCF, PCF+4, ValidD=1}; PCF <= PCF+4. Stay in FETCH.
  - imem_valid, Stall: capture imem_rdata into hold buffer. IF/ID and PCF hold. Go to HOLD.
  - !imem_valid, no Stall, no Flush: IF/ID <= bubble (NOP, ValidD=0, PCD/PCPlus4D hold); bubble_cnt++. PCF holds.
  - !imem_valid, Stall: everything holds.
  - Flush with imem_valid: discard response; PCF <= PCTargetE; IF/ID <= bubble. Stay in FETCH.
  - Flush with !imem_valid: saved_pc <= PCTargetE; IF/ID <= bubble. Go to DROP.
- State HOLD:
  - !Stall, no Flush: IF/ID <= {buffer, PCF, PCF+4, 1}; PCF <= PCF+4. Go to FETCH.
  - Stall: hold.
  - Flush: discard buffer; PCF <= PCTargetE; IF/ID <= bubble. Go to FETCH.
- State DROP:
  - imem_valid: discard response; PCF <= saved_pc (or PCTargetE if Flush is also high this cycle). Go to FETCH.
  - Flush without imem_valid: saved_pc <= PCTargetE.
  - IF/ID <= bubble unless Stall.
- IF/ID flush always produces NOP with ValidD=0. A bubble never sets ValidD.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFFFFFC wraps to 0. PCTargetE low 2 bits are ignored (forced 0).
- Counters: increment by 1 per qualifying cycle and saturate at all-ones. rst clears them.
- Reset mid-transaction: state returns to FETCH at RESET_PC. The memory is reset on the same rst, so no stale response can arrive.
- Stall and Flush in the same cycle: Flush wins; both counters increment.

Decomposition:
- Shared pipeline_pkg holds:
  - NOP_INSTR constant
  - fetch_state_t enum {FETCH, HOLD, DROP}
  - RESET_PC default
- One sub-module, sat_counter (parameter WIDTH; ports clk, rst, inc, count), instantiated three times.

Test Plan:
- Zero-wait memory (imem_valid tied 1), no hazards, 4 cycles after rst -> PCD sequence BFC00000..BFC0000C; ValidD=1 from cycle 1.
- Memory latency 2 on each fetch -> each instruction is preceded by one bubble (ValidD=0, InstrD=13); bubble_cnt=1 per fetch.
- imem_valid with Stall=1 for 3 cycles -> state HOLD, InstrD unchanged, stall_cnt=3. Release -> buffered instruction appears with correct PCD; PCF advances.
- Flush while request outstanding (latency 3) with PCTargetE=BFC00100 -> response discarded; next fetch imem_addr=BFC00100; no ValidD=1 for the dropped word.
- Stall=1 and Flush=1 in the same cycle in HOLD -> buffer discarded, PCF=target, stall_cnt and flush_cnt each +1.
- Counter saturation with CNT_WIDTH=3, Stall held 10 cycles -> stall_cnt stops at 7. rst mid-DROP -> imem_addr=BFC00000 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline front end.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count qualifying cycles, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, variable-latency imem handshake and perf counters.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Stall,
  input  logic                 Flush,
  input  logic [31:0]          PCTargetE,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_valid,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          InstrD,
  output logic [31:0]          PCD,
  output logic [31:0]          PCPlus4D,
  output logic                 ValidD,
  output logic                 ImemWait,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic [CNT_WIDTH-1:0] bubble_cnt
);

  fetch_state_t state;
  logic [31:0]  pcf;
  logic [31:0]  saved_pc;
  logic [31:0]  hold_buf;
  logic [31:0]  target;
  logic         bubble_inc;

  // Targets are word aligned; the low two bits are dropped.
  assign target = PCTargetE & ~32'd3;

  // PCF is never advanced while a dropped request is pending, so the address is always PCF.
  assign imem_req   = (state != HOLD);
  assign imem_addr  = pcf;
  assign ImemWait   = ((state == FETCH) && !imem_valid) || (state == DROP);
  assign bubble_inc = (state == FETCH) && !imem_valid && !Stall && !Flush;

  // Fetch FSM, PC and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pcf      <= RESET_PC;
      saved_pc <= '0;
      hold_buf <= '0;
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (Flush) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
            if (imem_valid) begin
              pcf <= target;
            end else begin
              saved_pc <= target;
              state    <= DROP;
            end
          end else if (Stall) begin
            if (imem_valid) begin
              hold_buf <= imem_rdata;
              state    <= HOLD;
            end
          end else if (imem_valid) begin
            InstrD   <= imem_rdata;
            PCD      <= pcf;
            PCPlus4D <= pcf + PC_STEP;
            ValidD   <= 1'b1;
            pcf      <= pcf + PC_STEP;
          end else begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
          end
        end
        HOLD: begin
          if (Flush) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
            pcf    <= target;
            state  <= FETCH;
          end else if (!Stall) begin
            InstrD   <= hold_buf;
            PCD      <= pcf;
            PCPlus4D <= pcf + PC_STEP;
            ValidD   <= 1'b1;
            pcf      <= pcf + PC_STEP;
            state    <= FETCH;
          end
        end
        DROP: begin
          if (imem_valid) begin
            pcf   <= Flush ? target : saved_pc;
            state <= FETCH;
          end else if (Flush) begin
            saved_pc <= target;
          end
          if (Flush || !Stall) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (Stall),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (Flush),
    .count (flush_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a variable-latency instruction memory model.
module tb_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC   = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, ImemWait;
  logic [31:0] stall_cnt, flush_cnt, bubble_cnt;

  logic        s_req, s_valid_d, s_wait;
  logic [31:0] s_addr, s_instr, s_pcd, s_pcp4;
  logic [2:0]  s_stall_cnt, s_flush_cnt, s_bubble_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned lat = 1;
  int unsigned wait_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Memory answers after lat cycles of a continuous request (lat=1 means same cycle).
  assign imem_valid = imem_req && ((wait_cnt + 1) >= lat);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (rst) wait_cnt <= 0;
    else if (imem_req && !imem_valid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  fetch_stage dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .ImemWait(ImemWait), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
  );

  fetch_stage #(.CNT_WIDTH(3)) u_small (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .PCTargetE(PCTargetE),
    .imem_req(s_req), .imem_addr(s_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .InstrD(s_instr), .PCD(s_pcd), .PCPlus4D(s_pcp4),
    .ValidD(s_valid_d), .ImemWait(s_wait), .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt), .bubble_cnt(s_bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; afterwards compare any newly issued IF/ID contents against the scoreboard.
  task automatic step();
    logic s, r;
    logic [31:0] e;
    @(posedge clk);
    s = Stall;
    r = rst;
    #1;
    if (!r && !s) begin
      if (ValidD) begin
        if (exp_q.size() == 0) begin
          check("extra_valid", {31'd0, ValidD}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pcd", PCD, e);
          check("instr", InstrD, mem_word(e));
          check("pcplus4", PCPlus4D, e + 32'd4);
        end
      end else begin
        check("bubble_nop", InstrD, NOP);
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int unsigned latency);
    lat = latency;
    Stall = 1'b0;
    Flush = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    steps(2);
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"}, imem_addr, RPC);
    check({tag, "_instr"}, InstrD, NOP);
    check({tag, "_pcd"}, PCD, 32'd0);
    check({tag, "_pcp4"}, PCPlus4D, 32'd0);
    check({tag, "_valid"}, {31'd0, ValidD}, 32'd0);
    check({tag, "_scnt"}, stall_cnt, 32'd0);
    check({tag, "_fcnt"}, flush_cnt, 32'd0);
    check({tag, "_bcnt"}, bubble_cnt, 32'd0);
  endtask

  task automatic check_drained(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset values and zero-wait streaming.
    do_reset(1);
    check_reset_state("rst");
    check("rst_req", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < 4; i++) exp_q.push_back(RPC + 32'(4 * i));
    steps(4);
    check_drained("zw_drain");
    check("zw_bcnt", bubble_cnt, 32'd0);

    // Latency 2: one bubble before each instruction.
    do_reset(2);
    for (int i = 0; i < 3; i++) exp_q.push_back(RPC + 32'(4 * i));
    steps(6);
    check_drained("lat2_drain");
    check("lat2_bcnt", bubble_cnt, 32'd3);

    // Stall with valid response -> HOLD, then release.
    do_reset(1);
    exp_q.push_back(RPC);
    step();
    Stall = 1'b1;
    steps(3);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    check("hold_instr", InstrD, mem_word(RPC));
    check("hold_scnt", stall_cnt, 32'd3);
    Stall = 1'b0;
    exp_q.push_back(RPC + 32'd4);
    exp_q.push_back(RPC + 32'd8);
    steps(2);
    check_drained("hold_drain");
    check("hold_addr", imem_addr, RPC + 32'd12);

    // Flush while a latency-3 request is outstanding.
    do_reset(3);
    Flush = 1'b1;
    PCTargetE = 32'hBFC0_0100;
    step();
    Flush = 1'b0;
    check("drop_wait", {31'd0, ImemWait}, 32'd1);
    check("drop_addr", imem_addr, RPC);
    steps(2);
    check("redir_addr", imem_addr, 32'hBFC0_0100);
    exp_q.push_back(32'hBFC0_0100);
    steps(3);
    check_drained("drop_drain");
    check("drop_fcnt", flush_cnt, 32'd1);

    // Stall and Flush together in HOLD; target low bits ignored.
    do_reset(1);
    Stall = 1'b1;
    step();
    Flush = 1'b1;
    PCTargetE = 32'hBFC0_0202;
    step();
    Stall = 1'b0;
    Flush = 1'b0;
    check("sf_addr", imem_addr, 32'hBFC0_0200);
    check("sf_valid", {31'd0, ValidD}, 32'd0);
    check("sf_instr", InstrD, NOP);
    check("sf_scnt", stall_cnt, 32'd2);
    check("sf_fcnt", flush_cnt, 32'd1);
    exp_q.push_back(32'hBFC0_0200);
    exp_q.push_back(32'hBFC0_0204);
    steps(2);
    check_drained("sf_drain");

    // Counter saturation on the 3-bit instance.
    do_reset(1);
    Stall = 1'b1;
    steps(10);
    check("sat_small", {29'd0, s_stall_cnt}, 32'd7);
    check("sat_wide", stall_cnt, 32'd10);
    Stall = 1'b0;
    exp_q.push_back(RPC);
    step();
    check_drained("sat_drain");

    // PC+4 wraps at the top of the address space.
    do_reset(1);
    Flush = 1'b1;
    PCTargetE = 32'hFFFF_FFFE;
    step();
    Flush = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    steps(2);
    check_drained("wrap_drain");

    // Reset in the middle of a dropped request.
    do_reset(3);
    Flush = 1'b1;
    PCTargetE = 32'hBFC0_0100;
    step();
    Flush = 1'b0;
    check("middrop_wait", {31'd0, ImemWait}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("middrop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
